hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core, and the source of the IF/ID register's `IDWrite` (hold) and `IF_Flush` controls. Each cycle it decides whether PC and IF/ID advance, hold, or flush, and whether ID/EX takes a bubble or holds. It detects load-use and ID-stage branch operand hazards combinationally. It also owns a registered state machine that stalls the front of the pipeline while the multi-cycle multiply/divide unit occupies EX.

---
 rtl/hazard_unit.sv | 218 +++++++++++++++++++++
 tb/tb_hazard_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the 5-stage MIPS core. It decides each cycle
// whether PC and IF/ID advance, hold or flush, and whether ID/EX takes a bubble
// or holds. Load-use and ID-stage branch operand hazards are detected
// combinationally. A small registered FSM (IDLE / MD_BUSY) freezes the front
// of the pipeline while the multi-cycle multiply/divide unit occupies EX.
//
// Parameters
//   MD_CYCLES      total EX occupancy of a mult/div instruction (2..63)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   IDEX_MemRead/RegWrite    load / register-write flags of the EX instruction
//   IDEX_Rt, IDEX_Rd         load and ALU destinations in EX
//   EXMEM_MemRead, EXMEM_Rt  load flag and destination in MEM
//   IFID_Rs, IFID_Rt         source registers of the ID instruction
//   IFID_Branch              ID instruction is beq/bne
//   Branch_Taken, Jump       ID branch taken / ID instruction is j/jal
//   MD_Start                 mult/div instruction present in EX
//   PCWrite, IDWrite         1 = hold PC / hold IF/ID
//   IF_Flush                 1 = load zero instruction into IF/ID
//   ID_Flush                 1 = bubble into ID/EX
//   EX_Hold                  1 = hold ID/EX contents
//   MD_Done                  pulse on the last EX cycle of a mult/div
//
// Optional feature (macro HAZARD_STATS_EN):
//   STALL_CNT, FLUSH_CNT     free-running 32-bit counters of IDWrite / IF_Flush
//                            cycles, wrapping, async reset to 0.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic [4:0] IDEX_Rt,
    input  logic [4:0] IDEX_Rd,
    input  logic       EXMEM_MemRead,
    input  logic [4:0] EXMEM_Rt,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_Branch,
    input  logic       Branch_Taken,
    input  logic       Jump,
    input  logic       MD_Start,
    output logic       PCWrite,
    output logic       IDWrite,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic       EX_Hold,
    output logic       MD_Done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_t;

    // Counter load value: the start cycle itself is the first of MD_CYCLES.
    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

    md_state_t  r_state;
    md_state_t  w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;

    logic w_lu;
    logic w_ba;
    logic w_bl;
    logic w_hazard;
    logic w_md_hold;
    logic w_md_done;

    // Register r0 is hard-wired zero, so a zero field never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        reg_match = (dst != 5'd0) && (dst == src);
    endfunction

    // Hazard detection from the current pipeline register contents.
    always_comb begin
        w_lu = IDEX_MemRead &&
               (reg_match(IDEX_Rt, IFID_Rs) || reg_match(IDEX_Rt, IFID_Rt));
        w_ba = IFID_Branch && IDEX_RegWrite &&
               (reg_match(IDEX_Rd, IFID_Rs) || reg_match(IDEX_Rd, IFID_Rt));
        w_bl = IFID_Branch && EXMEM_MemRead &&
               (reg_match(EXMEM_Rt, IFID_Rs) || reg_match(EXMEM_Rt, IFID_Rt));
        w_hazard = w_lu || w_ba || w_bl;
    end

    // MD FSM state register and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // MD FSM next-state and counter update.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (MD_Start) begin
                    w_state_next = ST_MD_BUSY;
                    w_cnt_next   = MD_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 6'd0;
                end
            end
            ST_MD_BUSY: begin
                // MD_Start stays high while the instruction sits in EX and is
                // deliberately ignored here. A zero count cannot occur in
                // normal operation; it falls back to IDLE rather than sticking.
                if (r_cnt > 6'd1) begin
                    w_state_next = ST_MD_BUSY;
                    w_cnt_next   = r_cnt - 6'd1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 6'd0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 6'd0;
            end
        endcase
    end

    // MD FSM outputs: hold covers the start cycle and every busy cycle but the last.
    always_comb begin
        w_md_hold = 1'b0;
        w_md_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_md_hold = MD_Start;
                w_md_done = 1'b0;
            end
            ST_MD_BUSY: begin
                w_md_hold = (r_cnt > 6'd1);
                w_md_done = (r_cnt == 6'd1);
            end
            default: begin
                w_md_hold = 1'b0;
                w_md_done = 1'b0;
            end
        endcase
    end

    // Pipeline control with priority reset > MD hold > data stall > flush.
    // Reset is applied here too so outputs drop without waiting for a clock.
    always_comb begin
        PCWrite  = 1'b0;
        IDWrite  = 1'b0;
        IF_Flush = 1'b0;
        ID_Flush = 1'b0;
        EX_Hold  = 1'b0;
        MD_Done  = 1'b0;
        if (rst) begin
            MD_Done = 1'b0;
        end else if (w_md_hold) begin
            PCWrite = 1'b1;
            IDWrite = 1'b1;
            EX_Hold = 1'b1;
        end else if (w_hazard) begin
            // The last MD cycle releases the hold, so hazards are acted on again.
            MD_Done  = w_md_done;
            PCWrite  = 1'b1;
            IDWrite  = 1'b1;
            ID_Flush = 1'b1;
        end else if (Branch_Taken || Jump) begin
            MD_Done  = w_md_done;
            IF_Flush = 1'b1;
        end else begin
            MD_Done = w_md_done;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Stall / flush cycle counters; natural 32-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (IDWrite) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (IF_Flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit. Two instances share all inputs: dut_a with
// MD_CYCLES=4 and dut_b with MD_CYCLES=12 (long enough to reach cnt=10 for the
// async-reset case). Output vectors are {PCWrite, IDWrite, IF_Flush, ID_Flush,
// EX_Hold, MD_Done}. Expected vectors are queued when stimulus is applied and
// popped when the outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic       IDEX_MemRead;
    logic       IDEX_RegWrite;
    logic [4:0] IDEX_Rt;
    logic [4:0] IDEX_Rd;
    logic       EXMEM_MemRead;
    logic [4:0] EXMEM_Rt;
    logic [4:0] IFID_Rs;
    logic [4:0] IFID_Rt;
    logic       IFID_Branch;
    logic       Branch_Taken;
    logic       Jump;
    logic       MD_Start;

    logic pcw_a, idw_a, iff_a, idf_a, exh_a, mdd_a;
    logic pcw_b, idw_b, iff_b, idf_b, exh_b, mdd_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    localparam logic [5:0] NONE   = 6'b000000;
    localparam logic [5:0] STALL  = 6'b110100;
    localparam logic [5:0] FLUSH  = 6'b001000;
    localparam logic [5:0] MDH    = 6'b110010;
    localparam logic [5:0] DONE   = 6'b000001;
    localparam logic [5:0] DONE_F = 6'b001001;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    wire [5:0] obs_a = {pcw_a, idw_a, iff_a, idf_a, exh_a, mdd_a};
    wire [5:0] obs_b = {pcw_b, idw_b, iff_b, idf_b, exh_b, mdd_b};

    hazard_unit #(.MD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rt(EXMEM_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_Branch(IFID_Branch), .Branch_Taken(Branch_Taken),
        .Jump(Jump), .MD_Start(MD_Start),
        .PCWrite(pcw_a), .IDWrite(idw_a), .IF_Flush(iff_a),
        .ID_Flush(idf_a), .EX_Hold(exh_a), .MD_Done(mdd_a)
`ifdef HAZARD_STATS_EN
        , .STALL_CNT(stall_cnt_a), .FLUSH_CNT(flush_cnt_a)
`endif
    );

    hazard_unit #(.MD_CYCLES(12)) dut_b (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rt(EXMEM_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_Branch(IFID_Branch), .Branch_Taken(Branch_Taken),
        .Jump(Jump), .MD_Start(MD_Start),
        .PCWrite(pcw_b), .IDWrite(idw_b), .IF_Flush(iff_b),
        .ID_Flush(idf_b), .EX_Hold(exh_b), .MD_Done(mdd_b)
`ifdef HAZARD_STATS_EN
        , .STALL_CNT(stall_cnt_b), .FLUSH_CNT(flush_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        IDEX_MemRead  = 1'b0;
        IDEX_RegWrite = 1'b0;
        IDEX_Rt       = 5'd0;
        IDEX_Rd       = 5'd0;
        EXMEM_MemRead = 1'b0;
        EXMEM_Rt      = 5'd0;
        IFID_Rs       = 5'd0;
        IFID_Rt       = 5'd0;
        IFID_Branch   = 1'b0;
        Branch_Taken  = 1'b0;
        Jump          = 1'b0;
        MD_Start      = 1'b0;
    endtask

    // Queue expectations for both instances, let outputs settle, then compare.
    task automatic chk(input logic [5:0] ea, input logic [5:0] eb, input string tag);
        logic [11:0] e;
        exp_q.push_back({ea, eb});
        #2;
        e = exp_q.pop_front();
        checks++;
        assert (obs_a === e[11:6]) else begin
            failures++;
            $error("FAIL %s dut_a outputs=%b expected=%b", tag, obs_a, e[11:6]);
        end
        checks++;
        assert (obs_b === e[5:0]) else begin
            failures++;
            $error("FAIL %s dut_b outputs=%b expected=%b", tag, obs_b, e[5:0]);
        end
    endtask

    initial begin
        logic [5:0] ea;
        logic [5:0] eb;

        // Reset: outputs forced low even with hazards and MD_Start present.
        rst = 1'b1;
        clr();
        MD_Start     = 1'b1;
        IDEX_MemRead = 1'b1;
        IDEX_Rt      = 5'd5;
        IFID_Rs      = 5'd5;
        Jump         = 1'b1;
        chk(NONE, NONE, "reset_out");
        cyc(); rst = 1'b0; clr();
        chk(NONE, NONE, "idle");

        // Load-use
        cyc(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        chk(STALL, STALL, "lu_rs");
        cyc(); clr();
        chk(NONE, NONE, "lu_clear");
        cyc(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd5; IFID_Rt = 5'd0;
        chk(NONE, NONE, "lu_r0");

        // Branch after load: LU then BL, then taken flush
        cyc(); clr(); IFID_Branch = 1'b1; IFID_Rs = 5'd8; IFID_Rt = 5'd2;
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rt = 5'd8;
        chk(STALL, STALL, "bl_lu");
        cyc(); IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_Rt = 5'd0;
        EXMEM_MemRead = 1'b1; EXMEM_Rt = 5'd8; Branch_Taken = 1'b1;
        chk(STALL, STALL, "bl_mem");
        cyc(); EXMEM_MemRead = 1'b0; EXMEM_Rt = 5'd0;
        chk(FLUSH, FLUSH, "bl_taken");
        cyc(); clr();
        chk(NONE, NONE, "bl_after");
`ifdef HAZARD_STATS_EN
        checks++;
        assert (stall_cnt_a === 32'd3) else begin
            failures++;
            $error("FAIL stall_cnt got=%0d expected=%0d", stall_cnt_a, 32'd3);
        end
        checks++;
        assert (flush_cnt_a === 32'd1) else begin
            failures++;
            $error("FAIL flush_cnt got=%0d expected=%0d", flush_cnt_a, 32'd1);
        end
`endif

        cyc(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rs = 5'd1; IFID_Rt = 5'd7;
        chk(STALL, STALL, "lu_rt");

        // Branch-ALU: stall wins over taken, flush follows once cleared
        cyc(); clr(); IFID_Branch = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd3;
        IFID_Rs = 5'd4; IFID_Rt = 5'd3; Branch_Taken = 1'b1;
        chk(STALL, STALL, "ba");
        cyc(); IDEX_RegWrite = 1'b0; IDEX_Rd = 5'd0;
        chk(FLUSH, FLUSH, "ba_flush");
        cyc(); IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd0; IFID_Rt = 5'd0;
        chk(FLUSH, FLUSH, "ba_r0");
        cyc(); clr(); Jump = 1'b1;
        chk(FLUSH, FLUSH, "jump");

        // Multiply: MD_Start and Jump high for 4 cycles, load-use present at t+1
        for (int k = 0; k < 12; k++) begin
            cyc(); clr();
            MD_Start = (k < 4);
            Jump     = (k < 4);
            if (k == 1) begin
                IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9;
            end
            ea = (k < 3) ? MDH : ((k == 3) ? DONE_F : NONE);
            eb = (k < 11) ? MDH : DONE;
            chk(ea, eb, $sformatf("md_k%0d", k));
        end
        cyc(); clr();
        chk(NONE, NONE, "md_after");

        // Async reset mid-busy (dut_b cnt=10 in the third cycle)
        for (int k = 0; k < 3; k++) begin
            cyc(); clr(); MD_Start = 1'b1;
            chk(MDH, MDH, $sformatf("rst_pre_k%0d", k));
        end
        rst = 1'b1;
        chk(NONE, NONE, "rst_async");
        cyc();
        chk(NONE, NONE, "rst_held");
        cyc(); rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            MD_Start = 1'b1;
            ea = ((k % 4) == 3) ? DONE : MDH;
            eb = (k == 11) ? DONE : MDH;
            chk(ea, eb, $sformatf("md_fresh_k%0d", k));
        end
        cyc(); clr();
        chk(NONE, NONE, "end_idle");

`ifdef HAZARD_STATS_EN
        force dut_a.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut_a.r_stall_cnt;
        cyc(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        chk(STALL, STALL, "wrap_s1");
        cyc();
        chk(STALL, STALL, "wrap_s2");
        cyc(); clr();
        chk(NONE, NONE, "wrap_after");
        checks++;
        assert (stall_cnt_a === 32'h0000_0000) else begin
            failures++;
            $error("FAIL stall_wrap got=%h expected=%h", stall_cnt_a, 32'h0000_0000);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
